la_readout_uart: RTL and testbench

Reader side of the logic-analyzer capture buffer. On a start command it reads a window of captured 8-bit samples from the synchronous-read sample RAM. It then streams them off-chip as 8N1 UART frames, preceded by a sync header byte. It sits between the capture RAM and a dedicated output pin in the tt_um_ top level.

---
 rtl/la_pkg.sv | 18 +
 rtl/la_uart_tx_byte.sv | 62 ++++++
 rtl/la_readout_uart.sv | 101 ++++++++++
 tb/tb_la_readout_uart.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyzer readout path: FSM encoding,
// sample width and default UART/header constants.
package la_pkg;

  localparam int SAMPLE_W = 8;
  localparam int DEF_CLKS_PER_BIT = 104;
  localparam logic [SAMPLE_W-1:0] DEF_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_FETCH = 3'd2,
    ST_WAIT  = 3'd3,
    ST_SEND  = 3'd4,
    ST_FIN   = 3'd5
  } la_state_e;

endpackage

// File: rtl/la_uart_tx_byte.sv
// 8N1 UART byte transmitter with a flop-driven line; frame_end flags the
// last cycle of the stop bit so the caller can sequence without a bubble.
module la_uart_tx_byte
  import la_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [SAMPLE_W-1:0] data,
  output logic                ready,
  output logic                frame_end,
  output logic                tx
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0]    baud_reg;
  logic [3:0]          bit_reg;
  logic [SAMPLE_W-1:0] shift_reg;
  logic                active_reg;
  logic                tx_reg;
  logic                bit_end;

  assign bit_end   = active_reg && (baud_reg == BAUD_LAST);
  assign frame_end = bit_end && (bit_reg == 4'd9);
  assign ready     = ~active_reg;
  assign tx        = tx_reg;

  // bit_reg 0 is the start bit, 1..8 data, 9 stop; ones shifted in supply the stop level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_reg   <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      active_reg <= 1'b0;
      tx_reg     <= 1'b1;
    end else if (!active_reg) begin
      if (valid) begin
        active_reg <= 1'b1;
        tx_reg     <= 1'b0;
        shift_reg  <= data;
        baud_reg   <= '0;
        bit_reg    <= '0;
      end
    end else if (bit_end) begin
      baud_reg <= '0;
      if (bit_reg == 4'd9) begin
        active_reg <= 1'b0;
      end else begin
        bit_reg   <= bit_reg + 4'd1;
        tx_reg    <= shift_reg[0];
        shift_reg <= {1'b1, shift_reg[SAMPLE_W-1:1]};
      end
    end else begin
      baud_reg <= baud_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/la_readout_uart.sv
// Capture-buffer reader: sends a sync header, then fetches each sample from
// the synchronous RAM and streams it out as an 8N1 UART frame.
module la_readout_uart
  import la_pkg::*;
#(
  parameter int                  CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int                  ADDR_W       = 6,
  parameter logic [SAMPLE_W-1:0] SYNC_BYTE    = DEF_SYNC_BYTE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     count,
  output logic                mem_rd,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [SAMPLE_W-1:0] mem_rdata,
  output logic                tx,
  output logic                busy,
  output logic                done
);

  la_state_e           state_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [ADDR_W:0]     remaining_reg;
  logic                tx_valid;
  logic [SAMPLE_W-1:0] tx_data;
  logic                tx_ready;
  logic                tx_frame_end;

  // Header launches on the accepting edge and samples launch straight out of
  // WAIT, so the line sees exactly FETCH+WAIT idle cycles between frames.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = SYNC_BYTE;
    case (state_reg)
      ST_IDLE: tx_valid = start && (count != '0);
      ST_WAIT: begin
        tx_valid = tx_ready;
        tx_data  = mem_rdata;
      end
      default: tx_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            if (count != '0) begin
              addr_reg      <= base_addr;
              remaining_reg <= count;
              state_reg     <= ST_HDR;
            end else begin
              state_reg <= ST_FIN;
            end
          end
        end
        ST_HDR: begin
          if (tx_frame_end) state_reg <= ST_FETCH;
        end
        ST_FETCH: state_reg <= ST_WAIT;
        ST_WAIT:  state_reg <= ST_SEND;
        ST_SEND: begin
          if (tx_frame_end) begin
            // natural overflow of addr_reg gives the modulo-DEPTH wrap
            addr_reg      <= addr_reg + ADDR_W'(1);
            remaining_reg <= remaining_reg - (ADDR_W+1)'(1);
            state_reg     <= (remaining_reg == (ADDR_W+1)'(1)) ? ST_FIN : ST_FETCH;
          end
        end
        ST_FIN:  state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign mem_rd   = (state_reg == ST_FETCH);
  assign mem_addr = addr_reg;
  assign done     = (state_reg == ST_FIN);
  assign busy     = (state_reg == ST_HDR) || (state_reg == ST_FETCH) ||
                    (state_reg == ST_WAIT) || (state_reg == ST_SEND);

  la_uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk      (clk),
    .rst      (rst),
    .valid    (tx_valid),
    .data     (tx_data),
    .ready    (tx_ready),
    .frame_end(tx_frame_end),
    .tx       (tx)
  );

endmodule

// File: tb/tb_la_readout_uart.sv
// Scoreboard bench for la_readout_uart: a RAM model, a mid-bit UART monitor
// and queues of expected bytes and read addresses.
module tb_la_readout_uart;

  localparam int CPB    = 4;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int FRAME  = 10 * CPB;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   count = '0;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata = 8'h00;
  logic              tx;
  logic              busy;
  logic              done;

  logic [7:0] mem [DEPTH];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  logic [7:0] exp_bytes[$];
  int         exp_addrs[$];

  bit         mon_active = 0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = 8'h00;
  int         frame_idx = 0;
  int         prev_start = 0;
  int         first_tx_cyc = -1;

  la_readout_uart #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (ADDR_W),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .count    (count),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // one read per sample, addresses in order
  always @(negedge clk) begin
    if (!rst && mem_rd) begin
      if (exp_addrs.size() == 0) check("spurious_mem_rd", 1, 0);
      else check("mem_addr", 32'(mem_addr), 32'(exp_addrs.pop_front()));
    end
  end

  // UART monitor: detect start bit, sample each bit at its midpoint
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst) begin
      mon_active = 0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1;
        mon_cnt = 0;
        if (frame_idx == 0) first_tx_cyc = cyc;
        else check("frame_spacing", 32'(cyc - prev_start), 32'(FRAME + 2));
        prev_start = cyc;
        frame_idx++;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == CPB / 2) begin
        check("start_bit", 32'(tx), 0);
      end else if (mon_cnt == 9 * CPB + CPB / 2) begin
        check("stop_bit", 32'(tx), 1);
        mon_active = 0;
        if (exp_bytes.size() == 0) begin
          check("unexpected_byte", 1, 0);
        end else begin
          e = exp_bytes.pop_front();
          $display("rx byte %02h (expected %02h) at cycle %0d", mon_byte, e, prev_start);
          check("rx_byte", 32'(mon_byte), 32'(e));
        end
      end else if ((mon_cnt - CPB / 2) % CPB == 0) begin
        mon_byte[(mon_cnt - CPB / 2) / CPB - 1] = tx;
      end
    end
  end

  task automatic push_exp(input int base, input int cnt);
    int a;
    if (cnt != 0) exp_bytes.push_back(8'hA5);
    for (int i = 0; i < cnt; i++) begin
      a = (base + i) % DEPTH;
      exp_addrs.push_back(a);
      exp_bytes.push_back(8'(8'h10 + a));
    end
  endtask

  task automatic run_readout(input int base, input int cnt, input bit extra);
    int acc, len, done_cyc;
    bit seen_done, busy_gap, busy_seen, tx_low;
    push_exp(base, cnt);
    frame_idx = 0;
    first_tx_cyc = -1;
    seen_done = 0; busy_gap = 0; busy_seen = 0; tx_low = 0; done_cyc = 0;
    @(negedge clk);
    start = 1'b1;
    base_addr = ADDR_W'(base);
    count = (ADDR_W+1)'(cnt);
    @(negedge clk);
    start = 1'b0;
    acc = cyc;
    len = (cnt == 0) ? 0 : (cnt + 1) * FRAME + 2 * cnt;
    check("busy_after_start", 32'(busy), 32'(cnt != 0));
    for (int i = 0; i < len + 100 && !seen_done; i++) begin
      if (done) begin
        seen_done = 1;
        done_cyc = cyc;
      end else begin
        if (busy) busy_seen = 1;
        else busy_gap = 1;
        if (tx === 1'b0) tx_low = 1;
        start = extra && (i == 60);
        if (extra && i == 60) begin
          base_addr = 4'd9;
          count = 5'd5;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    $display("readout base=%0d count=%0d: done at +%0d cycles", base, cnt, done_cyc - acc);
    check("done_seen", 32'(seen_done), 1);
    if (seen_done) check("done_latency", 32'(done_cyc - acc), 32'(len));
    if (cnt != 0) begin
      check("first_tx_cycle", 32'(first_tx_cyc), 32'(acc));
      check("busy_held", 32'(busy_gap), 0);
    end else begin
      check("busy_never", 32'(busy_seen), 0);
      check("tx_idle", 32'(tx_low), 0);
    end
    check("busy_at_done", 32'(busy), 0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);
    check("bytes_left", 32'(exp_bytes.size()), 0);
    check("reads_left", 32'(exp_addrs.size()), 0);
  endtask

  initial begin
    bit stray;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(8'h10 + i);
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_mem_rd", 32'(mem_rd), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_readout(2, 3, 0);
    run_readout(14, 4, 0);
    run_readout(0, 0, 0);
    run_readout(2, 3, 1);

    // reset in the middle of the second sample frame
    push_exp(2, 3);
    frame_idx = 0;
    @(negedge clk);
    start = 1'b1; base_addr = 4'd2; count = 5'd3;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2000 && frame_idx < 3; i++) @(negedge clk);
    check("reached_sample2", 32'(frame_idx >= 3), 1);
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_tx", 32'(tx), 1);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_bytes.delete();
    exp_addrs.delete();
    stray = 0;
    for (int i = 0; i < 30; i++) begin
      if (done || busy || tx !== 1'b1) stray = 1;
      @(negedge clk);
    end
    check("quiet_after_reset", 32'(stray), 0);
    run_readout(0, 1, 0);

    run_readout(5, 16, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
